// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Bits in one frame: R/W flag, address field, data field.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one raw pin plus a single-flop edge detector.
// RST_VAL sets the idle level held in every flop during reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw pin through the synchroniser and keep the previous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI Mode 0 peripheral with a parameterised register file, CIPO readback,
// write strobes and aborted-frame detection. Frame, MSB first:
// [ R/W | ADDR | DATA ], R/W=1 writes.
// Optional: define SPI_ERR_CNT_EN for a saturating frame-error counter
// readable (and write-clearable) at address NUM_REGS.
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FW    = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(FW + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] CMD_END = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] FRM_END = CNT_W'(FW);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

    assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

    spi_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [FW-2:0]    sh;
    logic [FW-1:0]    sh_next;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0] out_sh, rd_word;
    logic is_read;
    logic cnt_clr, shift_en, cmd_done, frame_done, abort;

    // Command fields appear in the low bits when the address completes;
    // full-frame fields come from the shift register including this bit.
    logic              cmd_rw, fr_rw;
    logic [ADDR_W-1:0] cmd_addr, fr_addr;
    logic [DATA_W-1:0] fr_data;
    logic cmd_valid, fr_valid, cmd_is_cnt, fr_is_cnt;
    logic err_now, wr_now;

    assign sh_next   = {sh, copi_lvl};
    assign cnt_inc   = cnt + CNT_W'(1);
    assign cmd_rw    = sh_next[ADDR_W];
    assign cmd_addr  = sh_next[ADDR_W-1:0];
    assign fr_rw     = sh_next[FW-1];
    assign fr_addr   = sh_next[DATA_W +: ADDR_W];
    assign fr_data   = sh_next[DATA_W-1:0];
    assign cmd_valid = int'(cmd_addr) < NUM_REGS;
    assign fr_valid  = int'(fr_addr) < NUM_REGS;
`ifdef SPI_ERR_CNT_EN
    assign cmd_is_cnt = int'(cmd_addr) == NUM_REGS;
    assign fr_is_cnt  = int'(fr_addr) == NUM_REGS;
`else
    assign cmd_is_cnt = 1'b0;
    assign fr_is_cnt  = 1'b0;
`endif
    assign err_now = abort | (frame_done & ~fr_valid & ~fr_is_cnt);
    assign wr_now  = frame_done & (fr_rw == RW_WRITE) & fr_valid;
    assign cipo_oe = ~ncs_lvl;
    assign regs_flat = regs;

`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Saturating frame-error count; a write to its address clears it.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (frame_done && fr_rw == RW_WRITE && fr_is_cnt)
            err_cnt <= '0;
        else if (err_now && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

    // Readback word selected when the address field completes.
    always_comb begin
        rd_word = '0;
        if (cmd_valid)
            rd_word = regs[cmd_addr[IDX_W-1:0]];
`ifdef SPI_ERR_CNT_EN
        else if (cmd_is_cnt)
            rd_word = DATA_W'(err_cnt);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle control; chip-select edges override SCLK.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        cmd_done   = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        if (ncs_fall) begin
            state_next = ST_CMD;
            cnt_clr    = 1'b1;
        end else if (ncs_rise) begin
            abort      = (state == ST_CMD) || (state == ST_DATA);
            state_next = ST_IDLE;
        end else if (sclk_rise) begin
            case (state)
                ST_CMD: begin
                    shift_en = 1'b1;
                    if (cnt_inc == CMD_END) begin
                        cmd_done   = 1'b1;
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (cnt_inc == FRM_END) begin
                        frame_done = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file writes on a committed, in-range write frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs    <= '0;
            wr_addr <= '0;
        end else if (wr_now) begin
            regs[fr_addr[IDX_W-1:0]] <= fr_data;
            wr_addr                  <= fr_addr;
        end
    end

    // Frame shifter, bit counter, status pulses and CIPO serialiser.
    // The fall right after the address completes precedes the first data
    // rise, so the MSB is held through it and shifting starts one fall later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh        <= '0;
            cnt       <= '0;
            out_sh    <= '0;
            is_read   <= 1'b0;
            cipo      <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= wr_now;
            frame_err <= err_now;
            if (cnt_clr) begin
                sh  <= '0;
                cnt <= '0;
            end else if (shift_en) begin
                sh  <= sh_next[FW-2:0];
                cnt <= cnt_inc;
            end
            if (cmd_done) begin
                is_read <= (cmd_rw == RW_READ);
                out_sh  <= rd_word;
            end else if (sclk_fall && state == ST_DATA && cnt != CMD_END) begin
                out_sh <= out_sh << 1;
            end
            if (state_next != ST_DATA)
                cipo <= 1'b0;
            else if (cmd_done)
                cipo <= (cmd_rw == RW_READ) & rd_word[DATA_W-1];
            else if (sclk_fall && is_read && cnt != CMD_END)
                cipo <= out_sh[DATA_W-2];
        end
    end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- Parametrised next-generation SPI Mode 0 peripheral: generic register count, address width and data width.
- Adds register readback on CIPO, write strobes and aborted-frame detection.
- Sits between the raw ui_in SPI pins and the PWM/output-enable logic.
- Frame format, MSB first: [ R/W(1) | ADDR(ADDR_W) | DATA(DATA_W) ], with R/W=1 for write and 0 for read.

Parameters:
- NUM_REGS, 5: number of implemented registers, at addresses 0..NUM_REGS-1.
- ADDR_W, 7: address field width.
- DATA_W, 8: data field and register width.
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  synchronous reset, active-high.
- sclk  in  1  raw SPI clock.
- copi  in  1  raw controller-out data.
- ncs  in  1  raw chip select, active-low.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  CIPO output enable (to uio_oe).
- regs_flat  out  NUM_REGS*DATA_W  register file; reg i occupies [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse on each committed write.
- wr_addr  out  ADDR_W  address of the last committed write.
- frame_err  out  1  one-cycle pulse on an aborted or invalid frame.

Behaviour:
- Reset (rst=1 at posedge clk):
  - regs_flat, cipo, cipo_oe, wr_strobe, wr_addr, frame_err and the bit counter all go to 0.
  - The synchroniser for ncs resets to 1; those for sclk and copi reset to 0.
  - The FSM goes to IDLE.
  - Reset mid-frame discards the frame with no commit.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flip-flops, then a 1-flop edge detector.
  - Derived events: sclk_rise, sclk_fall, ncs_fall, ncs_rise.
  - Timing requirement: the SCLK half-period must be at least SYNC_STAGES+3 clk periods.
- Counter: FRAME_W = 1+ADDR_W+DATA_W; the bit counter width is $clog2(FRAME_W+1).
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on ncs_fall; shift register and counter clear.
  - CMD: shift copi on each sclk_rise. On rise number 1+ADDR_W, latch rw and addr, then go to DATA.
  - DATA: shift copi on each sclk_rise. On rise number FRAME_W, commit, then go to DONE.
  - DONE: all further sclk edges are ignored until ncs_rise, then go to IDLE.
  - ncs_fall in any state restarts in CMD.
- Abort and invalid frames:
  - ncs_rise while in CMD or DATA returns to IDLE with no commit, and frame_err pulses.
  - If ncs_rise and sclk_rise are detected in the same cycle, ncs wins and the edge is ignored.
- Commit (write):
  - Occurs in the same clk cycle the final sclk_rise is detected, decoding the next-value of the shift register.
  - If rw=1 and addr<NUM_REGS: the register updates and is visible on the next cycle; wr_strobe pulses that same cycle; wr_addr<=addr.
  - If addr>=NUM_REGS (read or write): no register change; frame_err pulses at end of frame.
- Read:
  - At the CMD->DATA transition with rw=0: load the output shift register with reg[addr] if addr<NUM_REGS, else 0. cipo<=MSB.
  - On each subsequent sclk_fall in DATA: shift left and present the next bit.
  - Data is therefore stable before every data-phase SCLK rise.
  - A read does not modify any register.
- Output enable:
  - cipo_oe=1 whenever synced ncs is low; otherwise 0.
  - cipo=0 outside the DATA state of a read frame.

Optional Feature:
- Macro: SPI_ERR_CNT_EN.
- When defined:
  - An 8-bit saturating counter increments on each frame_err pulse (it stays at 255).
  - The counter is readable at address NUM_REGS.
  - A write to that address clears it; this write does not pulse frame_err.
- When undefined: no counter exists; address NUM_REGS is invalid like any other address >=NUM_REGS.

Decomposition:
- Package spi_pkg holds:
  - the FSM state enum typedef;
  - RW_WRITE=1 and RW_READ=0 constants;
  - a FRAME_W helper function.
- Sub-module spi_sync_edge: a SYNC_STAGES synchroniser plus rise/fall detector with a reset-value parameter. It is instantiated three times (sclk, copi, ncs).

Test Plan:
- Write 0xA5 to addr 0x02 (frame 0x82A5) -> reg2=0xA5 one clk after the 16th synced rise; single wr_strobe; wr_addr=2; other registers unchanged.
- Write 0x3C to addr 0x04, then read addr 0x04 (frame 0x04xx) -> cipo shifts out 0x3C MSB-first across data-phase rises; registers unchanged.
- Write to addr 0x05 with NUM_REGS=5, macro undefined -> no register change; one frame_err pulse; a read of addr 0x05 returns 0x00.
- Raise ncs after 10 bits of frame 0x81FF -> reg1 unchanged; frame_err pulse; FSM returns to IDLE; the next full frame 0x8155 gives reg1=0x55.
- Send 20 SCLKs on frame 0x8077 -> reg0=0x77; extra clocks ignored; no second strobe. Repeat the check with NUM_REGS=8, ADDR_W=3, DATA_W=16 on a 20-bit frame.
- Assert rst mid-DATA of frame 0x83FF -> all registers 0, no commit; with SPI_ERR_CNT_EN, 3 aborts followed by a read of addr NUM_REGS return 0x03.
